// File: rtl/ctrl_uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// ctrl_uart_rx_fifo_if
// Bundles the signals between the UART byte receiver and CPU register side
// (master) and the receive FIFO (slave).
//   in_dat/in_vld : received byte and its one-cycle valid strobe
//   rd            : pop strobe from a read of the RX data register
//   clr           : synchronous flush from a write to the status register
//   out_dat       : head byte, first-word-fall-through
//   empty/full    : fill status
//   level         : number of stored bytes, 0..2**AW
//   ovf           : sticky overflow flag
//   thr/irq       : fill threshold and threshold flag, present only when
//                   CTRL_UART_RX_FIFO_IRQ_EN is defined
// ---------------------------------------------------------------------------
interface ctrl_uart_rx_fifo_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [DW-1:0] in_dat;
  logic          in_vld;
  logic          rd;
  logic          clr;
  logic [DW-1:0] out_dat;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          ovf;
`ifdef CTRL_UART_RX_FIFO_IRQ_EN
  logic [AW:0]   thr;
  logic          irq;

  modport master (
    output in_dat, in_vld, rd, clr, thr,
    input  out_dat, empty, full, level, ovf, irq
  );
  modport slave (
    input  in_dat, in_vld, rd, clr, thr,
    output out_dat, empty, full, level, ovf, irq
  );
`else
  modport master (
    output in_dat, in_vld, rd, clr,
    input  out_dat, empty, full, level, ovf
  );
  modport slave (
    input  in_dat, in_vld, rd, clr,
    output out_dat, empty, full, level, ovf
  );
`endif
endinterface

// File: rtl/ctrl_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// ctrl_uart_rx_fifo
// Receive FIFO between the UART byte receiver and the CPU RX data/status
// registers. Stores up to 2**AW bytes, presents the head byte registered and
// first-word-fall-through, and reports level, empty, full and a sticky
// overflow flag.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ctrl_uart_rx_fifo_if.slave (in_dat, in_vld, rd, clr, out_dat,
//           empty, full, level, ovf [, thr, irq])
//
// Optional feature: define CTRL_UART_RX_FIFO_IRQ_EN to add the thr input and
// the registered irq output (irq = level >= thr, with thr == 0 disabling it).
// ---------------------------------------------------------------------------
module ctrl_uart_rx_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input logic               clk,
  input logic               rst_n,
  ctrl_uart_rx_fifo_if.slave bus
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic [DW-1:0] r_out_dat;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_rp_inc;
  logic [AW:0]   w_level_nxt;
  logic [DW-1:0] w_out_nxt;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == DEPTH);
  assign w_rp_inc = r_rp + AW'(1);

  always_comb begin
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_level_nxt = r_level;
    w_out_nxt   = r_out_dat;

    // clr overrides both ports, so neither a pop nor a push is accepted.
    if (!bus.clr) begin
      w_pop  = bus.rd && !w_empty;
      // A full FIFO still takes a byte when the head leaves in the same cycle.
      w_push = bus.in_vld && (!w_full || w_pop);
      w_drop = bus.in_vld && !w_push;
    end

    if (bus.clr)
      w_level_nxt = '0;
    else if (w_push && !w_pop)
      w_level_nxt = r_level + (AW+1)'(1);
    else if (w_pop && !w_push)
      w_level_nxt = r_level - (AW+1)'(1);

    // Head register: the byte that will sit at rp after this edge. When the
    // entry behind the head is the one being written now, it is taken
    // straight from in_dat because the array write lands on the same edge.
    // With nothing left to show, the last value is held.
    if (w_push && w_empty)
      w_out_nxt = bus.in_dat;
    else if (w_pop) begin
      if (r_level > (AW+1)'(1))
        w_out_nxt = r_mem[w_rp_inc];
      else if (w_push)
        w_out_nxt = bus.in_dat;
    end
  end

  // Storage is not reset; only pointers and flags carry reset values.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= bus.in_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_out_dat <= '0;
    end else begin
      r_level   <= w_level_nxt;
      r_out_dat <= w_out_nxt;
      if (bus.clr) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_push) r_wp  <= r_wp + AW'(1);
        if (w_pop)  r_rp  <= w_rp_inc;
        if (w_drop) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.out_dat = r_out_dat;
  assign bus.empty   = w_empty;
  assign bus.full    = w_full;
  assign bus.level   = r_level;
  assign bus.ovf     = r_ovf;

`ifdef CTRL_UART_RX_FIFO_IRQ_EN
  logic r_irq;
  logic w_irq_nxt;

  // Evaluated on the post-edge level so irq moves on the same edge as level.
  assign w_irq_nxt = !bus.clr && (bus.thr != '0) && (w_level_nxt >= bus.thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_irq <= 1'b0;
    else
      r_irq <= w_irq_nxt;
  end

  assign bus.irq = r_irq;
`endif

endmodule

// File: tb/tb_ctrl_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ctrl_uart_rx_fifo
// Self-checking bench for ctrl_uart_rx_fifo. A queue-based reference model
// tracks stored bytes, the sticky overflow flag, the visible head byte and
// (with CTRL_UART_RX_FIFO_IRQ_EN) the threshold flag.
// ---------------------------------------------------------------------------
module tb_ctrl_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_uart_rx_fifo_if #(.DW(DW), .AW(AW)) bus ();
  ctrl_uart_rx_fifo #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] m_out;
  logic       m_irq;

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_out = 8'h00;
    m_irq = 1'b0;
  endtask

  // One clock cycle of stimulus; the model is advanced at the edge and the
  // bench returns 1 time unit after it, ready to sample.
  task automatic cyc(input logic vld, input logic [7:0] d, input logic r, input logic c);
    bit pop, push;
    bus.in_vld = vld; bus.in_dat = d; bus.rd = r; bus.clr = c;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = r && (q.size() > 0);
      push = vld && ((q.size() < DEPTH) || pop);
      if (vld && !push) m_ovf = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
    if (q.size() > 0) m_out = q[0];
`ifdef CTRL_UART_RX_FIFO_IRQ_EN
    m_irq = !c && (bus.thr != 0) && (q.size() >= int'(bus.thr));
`endif
    #1;
    bus.in_vld = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic apply_reset();
    bus.in_vld = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0; bus.in_dat = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", bus.level); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.full); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    n_tests++; if (bus.out_dat !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h exp 00", bus.out_dat); end
`ifdef CTRL_UART_RX_FIFO_IRQ_EN
    n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    n_tests++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b exp 0", bus.empty); end
    n_tests++; if (bus.level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", bus.level); end
    n_tests++; if (bus.out_dat !== 8'h41) begin n_fail++; $display("FAIL single_out got %h exp 41", bus.out_dat); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty got %b exp 1", bus.empty); end
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL single_pop_level got %0d exp 0", bus.level); end
  endtask

  task automatic test_overflow();
    apply_reset(); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b exp 1", bus.full); end
    n_tests++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL ovf_fill_level got %0d exp 16", bus.level); end
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", bus.ovf); end
    n_tests++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d exp 16", bus.level); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (bus.out_dat !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, bus.out_dat, 8'(i)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained_empty got %b exp 1", bus.empty); end
    n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bus.ovf); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_b;
    apply_reset(); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    n_tests++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL fullpp_level got %0d exp 16", bus.level); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL fullpp_ovf got %b exp 0", bus.ovf); end
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'h21 + 8'(i) : 8'h55;
      n_tests++; if (bus.out_dat !== exp_b) begin n_fail++; $display("FAIL fullpp_drain[%0d] got %h exp %h", i, bus.out_dat, exp_b); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_empty_pushpop();
    apply_reset(); rst_n = 1'b1;
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    n_tests++; if (bus.level !== 5'd1) begin n_fail++; $display("FAIL emptypp_level got %0d exp 1", bus.level); end
    n_tests++; if (bus.out_dat !== 8'h33) begin n_fail++; $display("FAIL emptypp_out got %h exp 33", bus.out_dat); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL rd_empty_level got %0d exp 0", bus.level); end
    n_tests++; if (bus.out_dat !== 8'h33) begin n_fail++; $display("FAIL rd_empty_hold got %h exp 33", bus.out_dat); end
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    cyc(1'b1, 8'h45, 1'b0, 1'b0);
    n_tests++; if (bus.out_dat !== 8'h44) begin n_fail++; $display("FAIL rd_empty_head got %h exp 44", bus.out_dat); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.out_dat !== 8'h45) begin n_fail++; $display("FAIL rd_empty_next got %h exp 45", bus.out_dat); end
  endtask

  task automatic test_clr_and_reset();
    apply_reset(); rst_n = 1'b1;
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.level !== 5'd5 || bus.ovf !== 1'b1) begin n_fail++; $display("FAIL clr_setup got level %0d ovf %b exp 5 1", bus.level, bus.ovf); end
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL clr_level got %0d exp 0", bus.level); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b exp 1", bus.empty); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b exp 0", bus.ovf); end
    cyc(1'b1, 8'h78, 1'b0, 1'b0);
    n_tests++; if (bus.out_dat !== 8'h78 || bus.level !== 5'd1) begin n_fail++; $display("FAIL clr_after got out %h level %0d exp 78 1", bus.out_dat, bus.level); end
    // Overflow again, then drop rst_n between clock edges while a byte is pending.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    bus.in_vld = 1'b1; bus.in_dat = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL async_rst_level got %0d exp 0", bus.level); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL async_rst_ovf got %b exp 0", bus.ovf); end
    n_tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags got empty %b full %b exp 1 0", bus.empty, bus.full); end
    @(posedge clk); #1;
    n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL async_rst_hold got %0d exp 0", bus.level); end
    bus.in_vld = 1'b0;
    model_reset();
    rst_n = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    n_tests++; if (bus.out_dat !== 8'h5A || bus.level !== 5'd1) begin n_fail++; $display("FAIL rst_release got out %h level %0d exp 5a 1", bus.out_dat, bus.level); end
  endtask

  task automatic test_random();
    logic v, r, c;
    apply_reset(); rst_n = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (((k / 100) % 2) == 0) begin
        v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 63) == 0);
`ifdef CTRL_UART_RX_FIFO_IRQ_EN
      if ((k % 50) == 0) bus.thr = 5'($urandom_range(0, 16));
`endif
      cyc(v, 8'($urandom), r, c);
      n_tests++; if (bus.level !== 5'(q.size())) begin n_fail++; $display("FAIL rand_level[%0d] got %0d exp %0d", k, bus.level, q.size()); end
      n_tests++; if (bus.out_dat !== m_out) begin n_fail++; $display("FAIL rand_out[%0d] got %h exp %h", k, bus.out_dat, m_out); end
      n_tests++; if (bus.ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d] got %b exp %b", k, bus.ovf, m_ovf); end
      n_tests++; if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rand_flags[%0d] got empty %b full %b exp size %0d", k, bus.empty, bus.full, q.size()); end
`ifdef CTRL_UART_RX_FIFO_IRQ_EN
      n_tests++; if (bus.irq !== m_irq) begin n_fail++; $display("FAIL rand_irq[%0d] got %b exp %b", k, bus.irq, m_irq); end
`endif
    end
  endtask

`ifdef CTRL_UART_RX_FIFO_IRQ_EN
  task automatic test_irq();
    apply_reset(); rst_n = 1'b1;
    bus.thr = 5'd4;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_below got %b exp 0", bus.irq); end
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    n_tests++; if (bus.irq !== 1'b1 || bus.level !== 5'd4) begin n_fail++; $display("FAIL irq_at got irq %b level %0d exp 1 4", bus.irq, bus.level); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_pop got %b exp 0", bus.irq); end
    bus.thr = 5'd0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_thr0 got %b exp 0", bus.irq); end
    bus.thr = 5'd1;
    cyc(1'b1, 8'hE0, 1'b0, 1'b1);
    n_tests++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr got %b exp 0", bus.irq); end
    cyc(1'b1, 8'hE1, 1'b0, 1'b0);
    n_tests++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_thr1 got %b exp 1", bus.irq); end
    bus.thr = 5'd0;
  endtask
`endif

  initial begin
    bus.in_vld = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0; bus.in_dat = 8'h00;
`ifdef CTRL_UART_RX_FIFO_IRQ_EN
    bus.thr = 5'd0;
`endif
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_clr_and_reset();
`ifdef CTRL_UART_RX_FIFO_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_uart_rx_fifo.md
Name: ctrl_uart_rx_fifo

Overview:
Receive FIFO between the control block's UART byte receiver and the CPU-side UART RX data/status registers.
- Buffers each received 8N1 byte so the CPU can drain bursts without losing characters.
- Presents the head byte first-word-fall-through.
- Reports fill level, empty/full and a sticky overflow flag for the UART status register.

Parameters:
DW, 8, data width in bits (one UART character)
AW, 4, address width; depth = 2**AW entries (16)

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
in_dat  input  DW  received byte from UART receiver
in_vld  input  1  one-cycle strobe: in_dat holds a valid frame (stop bit good)
rd  input  1  pop strobe from register read of UART RX data; one pop per cycle high
clr  input  1  synchronous flush (CPU write to UART status)
out_dat  output  DW  head-of-FIFO byte; valid while empty=0
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds 2**AW bytes
level  output  AW+1  number of stored bytes, 0..2**AW
ovf  output  1  sticky overflow: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous): read/write pointers = 0, level = 0, empty = 1, full = 0, ovf = 0. out_dat = 0. Storage contents are not reset.
- Storage: 2**AW x DW register array.
  - Write pointer wp and read pointer rp are AW bits wide and wrap naturally from 2**AW-1 to 0.
  - level is a separate AW+1-bit counter. empty = (level==0) and full = (level==2**AW), both registered or derived from the registered level.
- Push: in_vld=1 and (full=0 or an accepted pop in the same cycle).
  - mem[wp] <= in_dat; wp increments.
- Pop: rd=1 and empty=0.
  - rp increments.
  - rd while empty is ignored: no pointer change, no error.
- Level update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Simultaneous events:
  - push+pop when full: both accepted; level stays 2**AW; no overflow.
  - push+pop when empty: push accepted, pop ignored; level becomes 1.
- Overflow: in_vld=1, full=1 and no pop that cycle → byte dropped, contents unchanged, ovf <= 1.
  - ovf stays set until clr or reset.
- clr has priority over push and pop in the same cycle.
  - wp, rp and level set to 0; ovf set to 0.
  - A push coincident with clr is discarded.
- Latency and out_dat:
  - out_dat is registered, first-word-fall-through.
  - After a push into an empty FIFO at edge N, empty=0 and out_dat = that byte from edge N onward. Visible in the next cycle.
  - After a pop at edge N, out_dat shows the next entry from edge N. A CPU read at cycle N sees the byte it pops.
  - When the FIFO is empty, out_dat holds its last value.
- Ordering: strict FIFO; bytes pop in push order across pointer wrap-around.
- Mid-operation reset: all state returns to reset values immediately; no partial pointer update on deassertion.
- Reset release: in_vld/rd are sampled normally from the first clk edge after rst_n rises.

Optional Feature:
- Macro: CTRL_UART_RX_FIFO_IRQ_EN.
- When defined, two extra ports are added:
  - thr input AW+1: fill threshold.
  - irq output 1: registered flag, irq <= (level_next >= thr) && (thr != 0).
  - irq reset value is 0.
  - irq updates in the same edge as level.
  - clr forces irq to 0 in that cycle.
- When not defined, thr and irq do not exist and no threshold logic is generated.

Test Plan:
- Reset, then push 0x41 → next cycle: empty=0, level=1, out_dat=0x41. Pulse rd → empty=1, level=0.
- Push 0x00..0x0F (16 bytes) → full=1, level=16. Push 0xAA → ovf=1, level=16. Pop all 16 → out_dat sequence 0x00..0x0F in order; 0xAA never appears.
- Fill to 16, then in one cycle push 0x55 and rd → level=16, ovf=0. Drain all 16 → 0x55 is the last byte.
- Empty FIFO: push 0x33 and rd same cycle → level=1, out_dat=0x33. rd alone on empty → level stays 0, no pointer change.
- Push 5 bytes with ovf set, then clr with a simultaneous push of 0x77 → level=0, empty=1, ovf=0, 0x77 discarded. Assert rst_n low mid-burst → level=0, ovf=0 asynchronously.
- With CTRL_UART_RX_FIFO_IRQ_EN, thr=4: push 3 bytes → irq=0; 4th push → irq=1 same edge as level=4; pop once → irq=0; thr=0 → irq stays 0.
